// File: rtl/bitcell_ctrl_pkg.sv
// Shared types for the bitcell array controller: FSM state and op encodings.
package bitcell_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RELEASE,
        ST_RESP
    } state_e;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; the pointer moves only on an accepted grant.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] gnt_o
);

    // prio_q = 1 means requester 1 wins a tie
    logic prio_q;
    logic prio_d;

    always_comb begin
        gnt_o = 2'b00;
        unique case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = prio_q ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
        endcase
    end

    always_comb begin
        prio_d = prio_q;
        if (accept_i) begin
            prio_d = gnt_o[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/bitcell_array_ctrl.sv
// Two-port sequencing controller for a NAND-latch bitcell array: arbitration,
// setup/access/release sequencing of sel, r_w and in, and read capture.
module bitcell_array_ctrl
    import bitcell_ctrl_pkg::*;
#(
    parameter int unsigned WORDS     = 8,
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned WR_CYCLES = 2,
    parameter int unsigned RD_CYCLES = 2,
    parameter int unsigned ADDR_W    = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic              req0_we_i,
    input  logic [ADDR_W-1:0] req0_addr_i,
    input  logic [WIDTH-1:0]  req0_wdata_i,
    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic              req1_we_i,
    input  logic [ADDR_W-1:0] req1_addr_i,
    input  logic [WIDTH-1:0]  req1_wdata_i,
    output logic              resp0_valid_o,
    output logic [WIDTH-1:0]  resp0_rdata_o,
    output logic              resp0_err_o,
    output logic              resp1_valid_o,
    output logic [WIDTH-1:0]  resp1_rdata_o,
    output logic              resp1_err_o,
    output logic [WORDS-1:0]  cell_sel_o,
    output logic              cell_r_w_o,
    output logic [WIDTH-1:0]  cell_in_o,
    input  logic [WIDTH-1:0]  cell_out_i
);

    localparam int unsigned MAXC  = (WR_CYCLES > RD_CYCLES) ? WR_CYCLES : RD_CYCLES;
    localparam int unsigned CNT_W = $clog2(MAXC + 1);

    state_e             state_q, state_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [WIDTH-1:0]   wdata_q, wdata_d;
    logic               port_q, port_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rdata_q, rdata_d;

    logic [1:0]         gnt;
    logic               idle;
    logic               accept;
    logic [WORDS-1:0]   dec;
    logic               in_range;
    logic               last_access;
    logic               active;
    logic               resp;
    logic [WIDTH-1:0]   rdata_out;

    assign idle   = (state_q == ST_IDLE);
    assign accept = idle && (|gnt);

    rr_arbiter2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    ({req1_valid_i, req0_valid_i}),
        .accept_i (accept),
        .gnt_o    (gnt)
    );

    assign req0_ready_o = idle && gnt[0];
    assign req1_ready_o = idle && gnt[1];

    // An address with no matching row leaves dec all-zero, which doubles as the error flag
    for (genvar g = 0; g < WORDS; g++) begin : g_dec
        assign dec[g] = (addr_q == ADDR_W'(g));
    end
    assign in_range = |dec;

    assign last_access = (cnt_q == ((we_q == OP_WRITE) ? CNT_W'(WR_CYCLES - 1)
                                                       : CNT_W'(RD_CYCLES - 1)));

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        port_d  = port_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SETUP;
                    port_d  = gnt[1];
                    we_d    = gnt[1] ? req1_we_i    : req0_we_i;
                    addr_d  = gnt[1] ? req1_addr_i  : req0_addr_i;
                    wdata_d = gnt[1] ? req1_wdata_i : req0_wdata_i;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
                cnt_d   = '0;
            end
            ST_ACCESS: begin
                if (last_access) begin
                    state_d = ST_RELEASE;
                    if (we_q == OP_READ) begin
                        rdata_d = in_range ? cell_out_i : '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RELEASE: state_d = ST_RESP;
            ST_RESP:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            port_q  <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            port_q  <= port_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    assign active     = state_q inside {ST_SETUP, ST_ACCESS, ST_RELEASE};
    assign cell_sel_o = active ? dec : '0;
    assign cell_r_w_o = (state_q == ST_ACCESS) && (we_q == OP_WRITE);
    assign cell_in_o  = (active && (we_q == OP_WRITE)) ? wdata_q : '0;

    assign resp      = (state_q == ST_RESP);
    assign rdata_out = (resp && (we_q == OP_READ) && in_range) ? rdata_q : '0;

    assign resp0_valid_o = resp && !port_q;
    assign resp1_valid_o = resp && port_q;
    assign resp0_rdata_o = port_q ? '0 : rdata_out;
    assign resp1_rdata_o = port_q ? rdata_out : '0;
    assign resp0_err_o   = resp0_valid_o && !in_range;
    assign resp1_err_o   = resp1_valid_o && !in_range;

endmodule

// File: tb/tb_bitcell_array_ctrl.sv
// Bench for bitcell_array_ctrl: transaction-level reference model compared every
// cycle, directed literal cases, randomized two-port traffic, and a latency-only second instance.
module tb_bitcell_array_ctrl;

    localparam int WORDS = 6;
    localparam int WIDTH = 4;
    localparam int WR    = 2;
    localparam int RD    = 2;
    localparam int AW    = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    // ---------------- main DUT (WORDS=6, addresses 6 and 7 are out of range)
    logic [1:0]       v = '0;
    logic [1:0]       we = '0;
    logic [AW-1:0]    ad [2];
    logic [WIDTH-1:0] wd [2];
    logic [1:0]       rdy, rv, rer;
    logic [WIDTH-1:0] rdt [2];
    logic [WORDS-1:0] sel;
    logic             rw;
    logic [WIDTH-1:0] cin;
    wire  [WIDTH-1:0] cout;

    bitcell_array_ctrl #(
        .WORDS(WORDS), .WIDTH(WIDTH), .WR_CYCLES(WR), .RD_CYCLES(RD)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid_i(v[0]), .req0_ready_o(rdy[0]), .req0_we_i(we[0]),
        .req0_addr_i(ad[0]), .req0_wdata_i(wd[0]),
        .req1_valid_i(v[1]), .req1_ready_o(rdy[1]), .req1_we_i(we[1]),
        .req1_addr_i(ad[1]), .req1_wdata_i(wd[1]),
        .resp0_valid_o(rv[0]), .resp0_rdata_o(rdt[0]), .resp0_err_o(rer[0]),
        .resp1_valid_o(rv[1]), .resp1_rdata_o(rdt[1]), .resp1_err_o(rer[1]),
        .cell_sel_o(sel), .cell_r_w_o(rw), .cell_in_o(cin), .cell_out_i(cout)
    );

    // Bitcell array: powers up with arbitrary contents, shared read bus floats when unselected
    logic [WIDTH-1:0] cells [WORDS];
    logic [WIDTH-1:0] cells_rd;
    always_comb begin
        cells_rd = '0;
        for (int i = 0; i < WORDS; i++) if (sel[i]) cells_rd = cells[i];
    end
    assign cout = (|sel && !rw) ? cells_rd : 'z;
    always @(posedge clk) begin
        if (rw) for (int i = 0; i < WORDS; i++) if (sel[i]) cells[i] <= cin;
    end

    // ---------------- reference model: one transaction at a time, cycle offset mk from handshake
    int               mk = 0;
    int               mn = 0;
    logic             mprio = 1'b0;
    logic             mwe = 1'b0;
    logic [AW-1:0]    maddr = '0;
    logic [WIDTH-1:0] mwd = '0;
    logic             mport = 1'b0;
    logic [WIDTH-1:0] mem [WORDS];
    bit               known [WORDS];

    function automatic logic [1:0] arb(input logic [1:0] r, input logic p);
        if (r == 2'b11) return p ? 2'b10 : 2'b01;
        return r;
    endfunction

    always @(negedge clk) begin
        logic [1:0]       erdy, erv;
        logic [WORDS-1:0] esel;
        logic             erw, eerr, inr, chk_rd;
        logic [WIDTH-1:0] ein, erd;
        erdy = '0; erv = '0; esel = '0; erw = 1'b0; eerr = 1'b0;
        ein = '0; erd = '0; chk_rd = 1'b1;
        inr = (int'(maddr) < WORDS);
        if (!rst_n) begin
            if (mk != 0 && mwe && inr) known[maddr] = 1'b0;
            mk = 0;
            mprio = 1'b0;
            erdy = arb(v, 1'b0);
        end else if (mk == 0) begin
            erdy = arb(v, mprio);
            if (|(erdy & v)) begin
                mport = erdy[1];
                mwe   = we[mport];
                maddr = ad[mport];
                mwd   = wd[mport];
                mn    = mwe ? WR : RD;
                mk    = 1;
                mprio = ~mport;
                if (mwe && int'(maddr) < WORDS) begin
                    mem[maddr]   = mwd;
                    known[maddr] = 1'b1;
                end
            end
        end else begin
            if (mk <= 2 + mn) begin
                if (inr) esel[maddr] = 1'b1;
                erw = mwe && (mk >= 2) && (mk <= 1 + mn);
                ein = mwe ? mwd : '0;
                mk  = mk + 1;
            end else begin
                erv[mport] = 1'b1;
                eerr = !inr;
                if (!mwe && inr) begin
                    erd    = mem[maddr];
                    chk_rd = known[maddr];
                end
                mk = 0;
            end
        end
        check("ready0", 32'(rdy[0]), 32'(erdy[0]));
        check("ready1", 32'(rdy[1]), 32'(erdy[1]));
        check("cell_sel", 32'(sel), 32'(esel));
        check("cell_r_w", 32'(rw), 32'(erw));
        check("cell_in", 32'(cin), 32'(ein));
        for (int p = 0; p < 2; p++) begin
            check(p == 0 ? "resp_valid0" : "resp_valid1", 32'(rv[p]), 32'(erv[p]));
            check(p == 0 ? "resp_err0" : "resp_err1", 32'(rer[p]), 32'(erv[p] & eerr));
            if (!(erv[p] && !chk_rd))
                check(p == 0 ? "resp_rdata0" : "resp_rdata1", 32'(rdt[p]),
                      32'(erv[p] ? erd : 4'h0));
        end
    end

    task automatic req(input int p, input logic w, input logic [AW-1:0] a,
                       input logic [WIDTH-1:0] d, output int lat,
                       output logic [WORDS-1:0] sel1, output int rwcnt,
                       output logic [WIDTH-1:0] rd, output logic er);
        int hs;
        lat = -1; sel1 = '0; rwcnt = 0; rd = '0; er = 1'b0; hs = -1;
        @(posedge clk); #1;
        v[p] = 1'b1; we[p] = w; ad[p] = a; wd[p] = d;
        for (int i = 0; i < 50 && hs < 0; i++) begin
            @(negedge clk);
            if (rdy[p]) hs = cyc;
        end
        if (hs < 0) begin
            fail("handshake");
            v[p] = 1'b0;
            return;
        end
        @(posedge clk); #1;
        v[p] = 1'b0;
        for (int i = 0; i < 50 && lat < 0; i++) begin
            @(negedge clk);
            if (cyc == hs + 1) sel1 = sel;
            if (rw) rwcnt++;
            if (rv[p]) begin
                lat = cyc - hs;
                rd  = rdt[p];
                er  = rer[p];
            end
        end
        if (lat < 0) fail("response");
    endtask

    // ---------------- second instance: WR_CYCLES=3, RD_CYCLES=1, latency only
    logic       b_v = 1'b0, b_we = 1'b0;
    logic [2:0] b_ad = '0;
    logic [3:0] b_wd = '0;
    logic       b_rdy, b_rdy1, b_rv, b_rv1, b_er, b_er1, b_rw;
    logic [3:0] b_rd, b_rd1, b_cin;
    logic [7:0] b_sel;
    wire  [3:0] b_cout;
    assign b_cout = (|b_sel && !b_rw) ? 4'h5 : 'z;

    bitcell_array_ctrl #(
        .WORDS(8), .WIDTH(4), .WR_CYCLES(3), .RD_CYCLES(1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req0_valid_i(b_v), .req0_ready_o(b_rdy), .req0_we_i(b_we),
        .req0_addr_i(b_ad), .req0_wdata_i(b_wd),
        .req1_valid_i(1'b0), .req1_ready_o(b_rdy1), .req1_we_i(1'b0),
        .req1_addr_i(3'd0), .req1_wdata_i(4'd0),
        .resp0_valid_o(b_rv), .resp0_rdata_o(b_rd), .resp0_err_o(b_er),
        .resp1_valid_o(b_rv1), .resp1_rdata_o(b_rd1), .resp1_err_o(b_er1),
        .cell_sel_o(b_sel), .cell_r_w_o(b_rw), .cell_in_o(b_cin), .cell_out_i(b_cout)
    );

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1);
    end

    initial begin
        int               lat, rwc, hs, ng;
        logic [WORDS-1:0] s1;
        logic [WIDTH-1:0] rd;
        logic             er;
        logic [1:0]       f;
        int               ord [4];
        logic [3:0]       brd;

        for (int i = 0; i < WORDS; i++) cells[i] = WIDTH'($urandom);
        ad[0] = '0; ad[1] = '0; wd[0] = '0; wd[1] = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_sel", 32'(sel), 32'h0);
        check("rst_resp0", 32'(rv[0]), 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;

        // write then read back address 3
        req(0, 1'b1, 3'd3, 4'hA, lat, s1, rwc, rd, er);
        check("wr_latency", 32'(lat), 32'd5);
        check("wr_setup_sel", 32'(s1), 32'h08);
        check("wr_rw_cycles", 32'(rwc), 32'd2);
        check("wr_err", 32'(er), 32'd0);
        req(0, 1'b0, 3'd3, 4'h0, lat, s1, rwc, rd, er);
        check("rd_latency", 32'(lat), 32'd5);
        check("rd_data", 32'(rd), 32'hA);
        check("rd_rw_cycles", 32'(rwc), 32'd0);

        // out-of-range write and read on port 1
        req(1, 1'b1, 3'd7, 4'hF, lat, s1, rwc, rd, er);
        check("oor_wr_sel", 32'(s1), 32'h0);
        check("oor_wr_err", 32'(er), 32'd1);
        req(1, 1'b0, 3'd6, 4'h0, lat, s1, rwc, rd, er);
        check("oor_rd_data", 32'(rd), 32'h0);
        check("oor_rd_err", 32'(er), 32'd1);

        // preload rows 1 and 2, reset, then contend with held reads
        req(0, 1'b1, 3'd1, 4'h3, lat, s1, rwc, rd, er);
        req(1, 1'b1, 3'd2, 4'hC, lat, s1, rwc, rd, er);
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        v = 2'b11; we = 2'b00; ad[0] = 3'd1; ad[1] = 3'd2;
        ng = 0;
        for (int i = 0; i < 200 && ng < 4; i++) begin
            @(negedge clk);
            if (v[0] && rdy[0]) begin ord[ng] = 0; ng++; end
            else if (v[1] && rdy[1]) begin ord[ng] = 1; ng++; end
        end
        @(posedge clk); #1 v = 2'b00;
        if (ng < 4) fail("rr_grants");
        else for (int k = 0; k < 4; k++) check("rr_order", 32'(ord[k]), 32'(k % 2));
        repeat (10) @(negedge clk);

        // asynchronous reset during the ACCESS phase of a write
        @(posedge clk); #1;
        v[0] = 1'b1; we[0] = 1'b1; ad[0] = 3'd2; wd[0] = 4'h5;
        hs = -1;
        for (int i = 0; i < 50 && hs < 0; i++) begin
            @(negedge clk);
            if (rdy[0]) hs = cyc;
        end
        if (hs < 0) fail("rst_handshake");
        @(posedge clk); #1 v[0] = 1'b0;
        @(posedge clk); #2;
        check("rw_before_rst", 32'(rw), 32'd1);
        rst_n = 1'b0; #1;
        check("rst_async_rw", 32'(rw), 32'd0);
        check("rst_async_sel", 32'(sel), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (8) @(negedge clk);
        req(0, 1'b1, 3'd2, 4'h6, lat, s1, rwc, rd, er);
        check("post_rst_wr_latency", 32'(lat), 32'd5);
        req(0, 1'b0, 3'd2, 4'h0, lat, s1, rwc, rd, er);
        check("post_rst_rd_data", 32'(rd), 32'h6);

        // randomized traffic on both ports; the model checks every cycle
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            f = v & rdy;
            @(posedge clk); #1;
            for (int p = 0; p < 2; p++) begin
                if (f[p]) v[p] = 1'b0;
                else if (v[p] && $urandom_range(0, 15) == 0) v[p] = 1'b0;
                else if (!v[p] && $urandom_range(0, 2) == 0) begin
                    v[p]  = 1'b1;
                    we[p] = 1'($urandom_range(0, 1));
                    ad[p] = AW'($urandom_range(0, 7));
                    wd[p] = WIDTH'($urandom);
                end
            end
        end
        @(posedge clk); #1 v = 2'b00;
        repeat (20) @(negedge clk);

        // latency with WR_CYCLES=3 / RD_CYCLES=1
        for (int op = 0; op < 2; op++) begin
            @(posedge clk); #1;
            b_v = 1'b1; b_we = (op == 0); b_ad = 3'd1; b_wd = 4'h9;
            hs = -1;
            for (int i = 0; i < 50 && hs < 0; i++) begin
                @(negedge clk);
                if (b_rdy) hs = cyc;
            end
            if (hs < 0) begin
                fail("b_handshake");
                b_v = 1'b0;
            end else begin
                @(posedge clk); #1 b_v = 1'b0;
                lat = -1; brd = '0;
                for (int i = 0; i < 50 && lat < 0; i++) begin
                    @(negedge clk);
                    if (b_rv) begin lat = cyc - hs; brd = b_rd; end
                end
                if (lat < 0) fail("b_response");
                else if (op == 0) check("b_wr_latency", 32'(lat), 32'd6);
                else begin
                    check("b_rd_latency", 32'(lat), 32'd4);
                    check("b_rd_data", 32'(brd), 32'h5);
                end
            end
        end
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
